// File: rtl/cache_ctrl_fsm_if.sv
// CPU and physical-memory handshake bundle for the L1 cache controller.
// Requests (mem_read/mem_write, pmem_read/pmem_write) are levels held until the matching one-cycle response pulse.
interface cache_ctrl_fsm_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;

  // master: CPU plus physical memory; slave: the cache controller
  modport master (
    output mem_read, mem_write, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );
  modport slave (
    input  mem_read, mem_write, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Control FSM for the 2-way set-associative write-back L1 cache: hit, writeback,
// fill and retry sequencing plus saturating hit/miss counters.
module cache_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  cache_ctrl_fsm_if.slave    bus,
  input  logic               hit,
  input  logic               hit_way,
  input  logic               lru_way,
  input  logic               victim_dirty,
  output logic               array_read,
  output logic [1:0]         tag_load,
  output logic [1:0]         valid_load,
  output logic [1:0]         dirty_load,
  output logic               dirty_in,
  output logic               lru_load,
  output logic               lru_in,
  output logic [1:0]         data_we,
  output logic               data_sel,
  output logic               addr_sel,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    WB    = 3'd2,
    FILL  = 3'd3,
    RETRY = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  state_t     state_nxt;
  logic       victim;
  logic       req;
  logic [1:0] hit_oh;
  logic [1:0] vic_oh;
  logic       mem_resp_c;
  logic       pmem_read_c;
  logic       pmem_write_c;

  assign req       = bus.mem_read | bus.mem_write;
  assign hit_oh    = {hit_way, ~hit_way};
  assign vic_oh    = {victim, ~victim};
  assign state_dbg = state;

  assign bus.mem_resp   = mem_resp_c;
  assign bus.pmem_read  = pmem_read_c;
  assign bus.pmem_write = pmem_write_c;

  // Victim way is captured on the miss decision so WB and FILL address the same way
  // even if the LRU array output moves afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      victim   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CHECK && !hit) victim <= lru_way;
      if (state == CHECK && hit && hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_ONE;
      if (state == CHECK && !hit && miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = CHECK;
      CHECK:   if (hit) state_nxt = IDLE;
               else if (victim_dirty) state_nxt = WB;
               else state_nxt = FILL;
      WB:      if (bus.pmem_resp) state_nxt = FILL;
      FILL:    if (bus.pmem_resp) state_nxt = RETRY;
      RETRY:   state_nxt = CHECK;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    array_read   = 1'b0;
    tag_load     = 2'b00;
    valid_load   = 2'b00;
    dirty_load   = 2'b00;
    dirty_in     = 1'b0;
    lru_load     = 1'b0;
    lru_in       = 1'b0;
    data_we      = 2'b00;
    data_sel     = 1'b0;
    addr_sel     = 1'b0;
    mem_resp_c   = 1'b0;
    pmem_read_c  = 1'b0;
    pmem_write_c = 1'b0;
    case (state)
      IDLE:  array_read = req;
      CHECK: begin
        if (hit) begin
          mem_resp_c = 1'b1;
          lru_load   = 1'b1;
          lru_in     = ~hit_way;
          if (bus.mem_write) begin
            data_we    = hit_oh;
            dirty_load = hit_oh;
            dirty_in   = 1'b1;
          end
        end
      end
      WB: begin
        pmem_write_c = 1'b1;
        addr_sel     = 1'b1;
      end
      FILL: begin
        pmem_read_c = 1'b1;
        // Line, tag, valid and a clean dirty bit land together on the response cycle.
        if (bus.pmem_resp) begin
          data_we    = vic_oh;
          data_sel   = 1'b1;
          tag_load   = vic_oh;
          valid_load = vic_oh;
          dirty_load = vic_oh;
        end
      end
      RETRY:   array_read = 1'b1;
      default: ;
    endcase
  end

endmodule
